aes_xif_result_buffer: RTL and testbench
========================================

Name: aes_xif_result_buffer

Overview:
- Result-side stage of the AES coprocessor. It sits between the AES datapath output and the CV-X-IF result interface that returns to the cv32e40x core.
- Buffers completed AES results in an in-order circular queue and presents them to the core with a valid/ready handshake.
- Honours commit-kill from the core by silently discarding killed results.
- Decouples datapath completion timing from core writeback back-pressure.

Parameters:
- X_ID_WIDTH, 4, width of the instruction ID field; matches the XIF instance.
- X_RFW_WIDTH, 32, result data width; matches the XIF instance.
- DEPTH, 4, number of queue entries; power of two, 2..16.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- res_valid_i  in  1  datapath result valid
- res_ready_o  out  1  buffer can accept a result
- res_id_i  in  X_ID_WIDTH  instruction ID of the pushed result
- res_data_i  in  X_RFW_WIDTH  AES result word
- res_rd_i  in  5  destination register
- res_we_i  in  1  register write enable
- commit_valid_i  in  1  XIF commit strobe
- commit_id_i  in  X_ID_WIDTH  committed/killed ID
- commit_kill_i  in  1  kill flag accompanying commit
- result_valid_o  out  1  XIF result valid
- result_ready_i  in  1  core accepts result
- result_id_o  out  X_ID_WIDTH  head ID
- result_data_o  out  X_RFW_WIDTH  head data
- result_rd_o  out  5  head rd
- result_we_o  out  1  head we
- count_o  out  $clog2(DEPTH)+1  occupied entries, including killed entries

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset (async assert, sync release): rd_ptr=wr_ptr=0, count=0, all kill flags=0, result_valid_o=0, result_id_o/data_o/rd_o/we_o=0, res_ready_o=1 after release, count_o=0.
- Storage: DEPTH entries {id, data, rd, we, killed}. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- res_ready_o = (count != DEPTH). It is combinational and independent of result_ready_i; a full buffer never accepts a push, even when a pop happens in the same cycle.
- Push occurs when res_valid_i && res_ready_o. The entry is written at wr_ptr with killed=0, and wr_ptr increments.
- Outputs are registered from the head entry. A result pushed into an empty buffer in cycle N gives result_valid_o=1 in cycle N+1.
- result_valid_o = (count != 0) && !head.killed.
- Accept occurs when result_valid_o && result_ready_i. The head pops and rd_ptr increments.
- If the head is killed, it pops autonomously (one per cycle) with result_valid_o=0. Ready is not required.
- Hold rule: while result_valid_o && !result_ready_i, all result_*_o stay stable. The only exception is a kill of the head.
- Kill handling:
  - When commit_valid_i && commit_kill_i, every occupied entry with id == commit_id_i has killed set in that cycle.
  - commit_valid_i with kill=0 has no effect.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged.
  - Push and kill of the same ID in the same cycle: the newly pushed entry is not killed (the kill precedes the push).
  - Kill of the head in the same cycle as an accept: the accept wins and the result is delivered.
  - Kill of a presented but unaccepted head: result_valid_o drops next cycle and the entry is discarded.
- count_o = wr-minus-rd occupancy. It counts from 0 to DEPTH with no overflow, because push is gated.
- Reset mid-operation discards all entries, including ones being presented, with no result delivered.
- Duplicate IDs in the queue are legal; a kill marks all of them.

Optional Feature:
- Macro AES_RESULT_BYPASS_EN.
- When defined: if count==0 and res_valid_i=1 with res_ready_o=1, result_valid_o and result_*_o are driven combinationally from res_*_i in the same cycle.
  - If result_ready_i=1 in that cycle, the result is consumed with no entry written and count stays 0.
  - If result_ready_i=0, the result is written normally and held from cycle N+1.
  - A kill of res_id_i in the same cycle suppresses the bypass and the entry is stored killed=0, per the push-wins rule.
- When undefined: minimum latency is 1 cycle, and all outputs are purely registered.

Test Plan:
- Reset with DEPTH=4; push id=3, data=32'hA5A5_0001, rd=5, we=1 with result_ready_i=1 -> result_valid_o=1 next cycle with identical fields; count_o returns to 0 one cycle after accept.
- Push ids 0,1,2,3 with result_ready_i=0 -> res_ready_o=0 and count_o=4; a 5th push is ignored. Raise ready -> results emerge in order 0,1,2,3 on 4 consecutive cycles, and res_ready_o=1 after the first pop.
- Queue ids 1,2,3; kill id=2 while id=1 is stalled -> delivered sequence is id 1 then id 3; the id 2 slot drains in one cycle with result_valid_o=0.
- Head id=7 presented, ready=0, kill id=7 -> result_valid_o=0 next cycle, count decrements, and no handshake occurs. Repeat with ready=1 in the kill cycle -> id 7 is delivered.
- Fill/drain 20 results continuously with random ready (pointer wrap ×5) -> data order is preserved, no loss or duplication, and count_o never exceeds 4.
- Assert rst_i mid-stream with 3 entries queued -> all outputs 0 immediately (async); after release, count_o=0 and no stale result appears. With AES_RESULT_BYPASS_EN, a push into an empty buffer with ready=1 -> result_valid_o in the same cycle and count_o stays 0.

Source files
------------

// File: rtl/aes_xif_result_buffer.sv
// In-order result queue between the AES datapath and the CV-X-IF result port, with commit-kill discard.
// Optional macro AES_RESULT_BYPASS_EN forwards a result combinationally when the queue is empty.
module aes_xif_result_buffer #(
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      res_valid_i,
    output logic                      res_ready_o,
    input  logic [X_ID_WIDTH-1:0]     res_id_i,
    input  logic [X_RFW_WIDTH-1:0]    res_data_i,
    input  logic [4:0]                res_rd_i,
    input  logic                      res_we_i,
    input  logic                      commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]     commit_id_i,
    input  logic                      commit_kill_i,
    output logic                      result_valid_o,
    input  logic                      result_ready_i,
    output logic [X_ID_WIDTH-1:0]     result_id_o,
    output logic [X_RFW_WIDTH-1:0]    result_data_o,
    output logic [4:0]                result_rd_o,
    output logic                      result_we_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [X_ID_WIDTH-1:0]  id_q   [DEPTH];
    logic [X_ID_WIDTH-1:0]  id_d   [DEPTH];
    logic [X_RFW_WIDTH-1:0] data_q [DEPTH];
    logic [X_RFW_WIDTH-1:0] data_d [DEPTH];
    logic [4:0]             rd_q   [DEPTH];
    logic [4:0]             rd_d   [DEPTH];
    logic [DEPTH-1:0]       we_q, we_d;
    logic [DEPTH-1:0]       killed_q, killed_d;

    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic                   out_valid_q, out_valid_d;
    logic [X_ID_WIDTH-1:0]  out_id_q, out_id_d;
    logic [X_RFW_WIDTH-1:0] out_data_q, out_data_d;
    logic [4:0]             out_rd_q, out_rd_d;
    logic                   out_we_q, out_we_d;

    logic                   kill_req;
    logic                   bypass_live;
    logic                   bypass_take;
    logic                   push;
    logic                   accept;
    logic                   head_killed;
    logic                   pop;
    logic [PTR_W-1:0]       offset;

    assign res_ready_o = (count_q != FULL_CNT);
    assign count_o     = count_q;
    assign kill_req    = commit_valid_i && commit_kill_i;

    // A same-cycle kill of the incoming ID blocks forwarding; the entry is then stored unkilled.
    always_comb begin
`ifdef AES_RESULT_BYPASS_EN
        bypass_live = (count_q == '0) && res_valid_i &&
                      !(kill_req && (commit_id_i == res_id_i));
`else
        bypass_live = 1'b0;
`endif
        bypass_take = bypass_live && result_ready_i;
    end

    always_comb begin
        id_d     = id_q;
        data_d   = data_q;
        rd_d     = rd_q;
        we_d     = we_q;
        killed_d = killed_q;
        offset   = '0;

        push        = res_valid_i && res_ready_o && !bypass_take;
        accept      = out_valid_q && result_ready_i;
        head_killed = (count_q != '0) && killed_q[rd_ptr_q];
        pop         = accept || head_killed;

        // Kill is applied to the occupied window first so that a simultaneous push stays live.
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr_q;
            if (kill_req && ({1'b0, offset} < count_q) && (id_q[i] == commit_id_i)) begin
                killed_d[i] = 1'b1;
            end
        end

        if (push) begin
            id_d[wr_ptr_q]     = res_id_i;
            data_d[wr_ptr_q]   = res_data_i;
            rd_d[wr_ptr_q]     = res_rd_i;
            we_d[wr_ptr_q]     = res_we_i;
            killed_d[wr_ptr_q] = 1'b0;
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        // Output registers always mirror the head the queue will hold after this edge.
        out_valid_d = (count_d != '0) && !killed_d[rd_ptr_d];
        out_id_d    = out_valid_d ? id_d[rd_ptr_d]   : '0;
        out_data_d  = out_valid_d ? data_d[rd_ptr_d] : '0;
        out_rd_d    = out_valid_d ? rd_d[rd_ptr_d]   : '0;
        out_we_d    = out_valid_d ? we_d[rd_ptr_d]   : 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i]   <= '0;
                data_q[i] <= '0;
                rd_q[i]   <= '0;
            end
            we_q        <= '0;
            killed_q    <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_we_q    <= 1'b0;
        end else begin
            id_q        <= id_d;
            data_q      <= data_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            killed_q    <= killed_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            out_we_q    <= out_we_d;
        end
    end

`ifdef AES_RESULT_BYPASS_EN
    assign result_valid_o = out_valid_q || bypass_live;
    assign result_id_o    = bypass_live ? res_id_i   : out_id_q;
    assign result_data_o  = bypass_live ? res_data_i : out_data_q;
    assign result_rd_o    = bypass_live ? res_rd_i   : out_rd_q;
    assign result_we_o    = bypass_live ? res_we_i   : out_we_q;
`else
    assign result_valid_o = out_valid_q;
    assign result_id_o    = out_id_q;
    assign result_data_o  = out_data_q;
    assign result_rd_o    = out_rd_q;
    assign result_we_o    = out_we_q;
`endif

endmodule

// File: tb/tb_aes_xif_result_buffer.sv
// Scoreboard bench for aes_xif_result_buffer: a queue-with-kill-flags reference model predicts every presented result.
module tb_aes_xif_result_buffer;

    localparam int IDW   = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            res_valid_i = 1'b0;
    logic            res_ready_o;
    logic [IDW-1:0]  res_id_i = '0;
    logic [DW-1:0]   res_data_i = '0;
    logic [4:0]      res_rd_i = '0;
    logic            res_we_i = 1'b0;
    logic            commit_valid_i = 1'b0;
    logic [IDW-1:0]  commit_id_i = '0;
    logic            commit_kill_i = 1'b0;
    logic            result_valid_o;
    logic            result_ready_i = 1'b0;
    logic [IDW-1:0]  result_id_o;
    logic [DW-1:0]   result_data_o;
    logic [4:0]      result_rd_o;
    logic            result_we_o;
    logic [2:0]      count_o;

    aes_xif_result_buffer #(
        .X_ID_WIDTH (IDW),
        .X_RFW_WIDTH(DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .res_valid_i   (res_valid_i),
        .res_ready_o   (res_ready_o),
        .res_id_i      (res_id_i),
        .res_data_i    (res_data_i),
        .res_rd_i      (res_rd_i),
        .res_we_i      (res_we_i),
        .commit_valid_i(commit_valid_i),
        .commit_id_i   (commit_id_i),
        .commit_kill_i (commit_kill_i),
        .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i),
        .result_id_o   (result_id_o),
        .result_data_o (result_data_o),
        .result_rd_o   (result_rd_o),
        .result_we_o   (result_we_o),
        .count_o       (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic [4:0]     rd;
        logic           we;
        logic           killed;
    } entry_t;

    entry_t sb[$];
    int     delivered[$];
    int     num_checks = 0;
    int     num_errors = 0;
    int     pre_size = 0;
    bit     bypass_consumed = 1'b0;
    int     pushes = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        num_checks++;
        if (act !== req) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: samples 1 time unit after inputs change, pops the model on delivery or on a killed head.
    always @(negedge clk_i) begin
        entry_t ex;
        bit     exp_valid;
        bit     from_bypass;
        #1;
        if (!rst_i) begin
            exp_valid       = 1'b0;
            from_bypass     = 1'b0;
            bypass_consumed = 1'b0;
            ex              = '{id: '0, data: '0, rd: '0, we: 1'b0, killed: 1'b0};
            pre_size        = sb.size();
            if (sb.size() != 0 && !sb[0].killed) begin
                exp_valid = 1'b1;
                ex        = sb[0];
            end
`ifdef AES_RESULT_BYPASS_EN
            else if (sb.size() == 0 && res_valid_i &&
                     !(commit_valid_i && commit_kill_i && commit_id_i == res_id_i)) begin
                exp_valid   = 1'b1;
                from_bypass = 1'b1;
                ex          = '{id: res_id_i, data: res_data_i, rd: res_rd_i, we: res_we_i, killed: 1'b0};
            end
`endif
            checkOutput("result_valid", 64'(result_valid_o), 64'(exp_valid));
            checkOutput("count", 64'(count_o), 64'(pre_size));
            checkOutput("res_ready", 64'(res_ready_o), 64'(pre_size != DEPTH));
            if (exp_valid) begin
                checkOutput("result_id", 64'(result_id_o), 64'(ex.id));
                checkOutput("result_data", 64'(result_data_o), 64'(ex.data));
                checkOutput("result_rd", 64'(result_rd_o), 64'(ex.rd));
                checkOutput("result_we", 64'(result_we_o), 64'(ex.we));
            end
            if (exp_valid && result_ready_i) begin
                delivered.push_back(int'(ex.id));
                if (from_bypass) bypass_consumed = 1'b1;
                else void'(sb.pop_front());
            end else if (sb.size() != 0 && sb[0].killed) begin
                void'(sb.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [IDW-1:0] id, input logic [DW-1:0] data,
                                 input logic [4:0] rd, input logic we, input logic cv, input logic kv,
                                 input logic [IDW-1:0] kid, input logic rdy);
        entry_t e;
        @(negedge clk_i);
        res_valid_i    = v;
        res_id_i       = id;
        res_data_i     = data;
        res_rd_i       = rd;
        res_we_i       = we;
        commit_valid_i = cv;
        commit_kill_i  = kv;
        commit_id_i    = kid;
        result_ready_i = rdy;
        #2;
        if (!rst_i) begin
            if (cv && kv) begin
                for (int i = 0; i < sb.size(); i++) begin
                    if (sb[i].id == kid) begin
                        e        = sb[i];
                        e.killed = 1'b1;
                        sb[i]    = e;
                    end
                end
            end
            if (v && pre_size != DEPTH && !bypass_consumed) begin
                sb.push_back('{id: id, data: data, rd: rd, we: we, killed: 1'b0});
                pushes++;
            end
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0, rdy);
    endtask

    task automatic push(input logic [IDW-1:0] id, input logic [DW-1:0] data, input logic rdy);
        applyStimulus(1'b1, id, data, 5'(id + 4'd1), id[0], 1'b0, 1'b0, '0, rdy);
    endtask

    task automatic kill(input logic [IDW-1:0] id, input logic rdy);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1, id, rdy);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            idle(1, 1'b1);
            n++;
        end
        idle(2, 1'b1);
        if (sb.size() != 0) begin
            num_checks++;
            num_errors++;
            $display("[TB] FAIL drain_timeout: %0d entries left, expected 0", sb.size());
        end
    endtask

    task automatic checkSequence(input string name, input int exp_ids[$]);
        checkOutput({name, "_len"}, 64'(delivered.size()), 64'(exp_ids.size()));
        for (int i = 0; i < exp_ids.size() && i < delivered.size(); i++) begin
            checkOutput({name, "_id"}, 64'(delivered[i]), 64'(exp_ids[i]));
        end
        delivered.delete();
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_valid"}, 64'(result_valid_o), 64'd0);
        checkOutput({name, "_id"}, 64'(result_id_o), 64'd0);
        checkOutput({name, "_data"}, 64'(result_data_o), 64'd0);
        checkOutput({name, "_rd"}, 64'(result_rd_o), 64'd0);
        checkOutput({name, "_we"}, 64'(result_we_o), 64'd0);
        checkOutput({name, "_count"}, 64'(count_o), 64'd0);
    endtask

    initial begin
        logic cv, kv;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        checkResetOutputs("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        $display("[TB] single result with ready high");
        push(4'd3, 32'hA5A5_0001, 1'b1);
        drain();
        checkSequence("single", '{3});

        $display("[TB] fill to full, extra push, then drain");
        for (int i = 0; i < 4; i++) push(4'(i), 32'h1000_0000 + 32'(i), 1'b0);
        push(4'd9, 32'hDEAD_BEEF, 1'b0);
        idle(1, 1'b0);
        drain();
        checkSequence("full", '{0, 1, 2, 3});

        $display("[TB] kill a middle entry behind a stalled head");
        for (int i = 1; i < 4; i++) push(4'(i), 32'h2000_0000 + 32'(i), 1'b0);
        kill(4'd2, 1'b0);
        idle(1, 1'b0);
        drain();
        checkSequence("midkill", '{1, 3});

        $display("[TB] kill of a stalled head, then kill coinciding with accept");
        push(4'd7, 32'h7777_0001, 1'b0);
        idle(1, 1'b0);
        kill(4'd7, 1'b0);
        idle(3, 1'b0);
        checkSequence("headkill", '{});
        push(4'd7, 32'h7777_0002, 1'b0);
        idle(1, 1'b0);
        kill(4'd7, 1'b1);
        drain();
        checkSequence("acceptwins", '{7});

        $display("[TB] push and kill of the same id in one cycle");
        applyStimulus(1'b1, 4'd5, 32'h5555_0005, 5'd9, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0);
        idle(1, 1'b0);
        drain();
        checkSequence("pushkill", '{5});

`ifdef AES_RESULT_BYPASS_EN
        $display("[TB] bypass into an empty buffer");
        push(4'd4, 32'hB1B1_0004, 1'b1);
        push(4'd6, 32'hB1B1_0006, 1'b0);
        drain();
        checkSequence("bypass", '{4, 6});
`endif

        $display("[TB] randomized traffic");
        pushes = 0;
        for (int n = 0; n < 300 && pushes < 24; n++) begin
            cv = ($urandom_range(0, 3) == 0);
            kv = cv && ($urandom_range(0, 1) == 1);
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                          cv, kv, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        drain();
        delivered.delete();

        $display("[TB] reset with entries queued");
        for (int i = 0; i < 3; i++) push(4'(i + 8), 32'hC0C0_0000 + 32'(i), 1'b0);
        @(negedge clk_i);
        #3;
        rst_i          = 1'b1;
        res_valid_i    = 1'b0;
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
        #1;
        checkResetOutputs("midreset");
        sb.delete();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        idle(3, 1'b1);
        checkSequence("postreset", '{});

        $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
        $finish;
    end

endmodule
